// File: rtl/icache_assoc_if.sv
`default_nettype none
// ============================================================================
//  icache_assoc_if
//  Fetch-side and memory-side signal bundle of the instruction cache.
//  Rev 1.0 - initial release
// ============================================================================
interface icache_assoc_if;
  // datapath fetch side
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  // memory controller side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // cache side
  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // datapath / controller side
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  icache_assoc
//  Set-associative instruction cache, multi-word blocks, combinational hit,
//  block-fill FSM on miss, invalid-first then true-LRU victim selection.
//  Rev 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int CPUID = 0,
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_assoc_if.slave bus_io
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = 30 - OFF_BITS - IDX_W;
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W    = WAY_W;

  // Elaboration-time parameter sanity checks
  if (CPUID < 0) begin : g_bad_cpuid
    $error("icache_assoc: CPUID must be non-negative");
  end
  if ((SETS < 2) || (SETS > 64) || ((SETS & (SETS - 1)) != 0)) begin : g_bad_sets
    $error("icache_assoc: SETS must be a power of 2 in 2..64");
  end
  if ((WAYS != 1) && (WAYS != 2) && (WAYS != 4)) begin : g_bad_ways
    $error("icache_assoc: WAYS must be 1, 2 or 4");
  end
  if ((WORDS != 1) && (WORDS != 2) && (WORDS != 4)) begin : g_bad_words
    $error("icache_assoc: WORDS must be 1, 2 or 4");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t state_q, state_d;

  // line storage
  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] ltag_q  [SETS][WAYS];
  logic [31:0]      data_q  [SETS][WAYS][WORDS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];

  // fill bookkeeping
  logic [TAG_W-1:0] mtag_q;
  logic [IDX_W-1:0] midx_q;
  logic [WAY_W-1:0] victim_q;
  logic [OFF_W-1:0] cnt_q;
  logic [31:0]      buf_q [WORDS];

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_match;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_victim;
  logic [AGE_W-1:0] w_max_age;
  logic             w_accept, w_last, w_install, w_hit, w_miss;
  logic             w_touch_en;
  logic [IDX_W-1:0] w_touch_idx;
  logic [WAY_W-1:0] w_touch_way;
  logic [AGE_W-1:0] w_old_age;
  logic [AGE_W-1:0] w_new_age [WAYS];

  assign w_tag = TAG_W'(bus_io.imemaddr >> (2 + OFF_BITS + IDX_W));
  assign w_idx = IDX_W'(bus_io.imemaddr >> (2 + OFF_BITS));
  assign w_off = OFF_W'((bus_io.imemaddr >> 2) & 32'(WORDS - 1));

  // Tag compare across all ways of the indexed set
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w_idx][w] && (ltag_q[w_idx][w] == w_tag)) begin
        w_match   = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: oldest way, overridden by the lowest-index invalid way
  always_comb begin
    w_victim  = '0;
    w_max_age = age_q[w_idx][0];
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[w_idx][w] > w_max_age) begin
        w_max_age = age_q[w_idx][w];
        w_victim  = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w_idx][w]) w_victim = WAY_W'(w);
    end
  end

  assign w_accept  = (state_q == S_FILL) && !bus_io.iwait;
  assign w_last    = (32'(cnt_q) == 32'(WORDS - 1));
  assign w_install = w_accept && w_last && !bus_io.flush;
  assign w_hit     = (state_q == S_IDLE) && bus_io.imemREN && !bus_io.flush && w_match;
  assign w_miss    = (state_q == S_IDLE) && bus_io.imemREN && !bus_io.flush && !w_match;

  // Age update for the way being touched (hit or install never coincide)
  always_comb begin
    w_touch_en  = w_install || w_hit;
    w_touch_idx = w_install ? midx_q : w_idx;
    w_touch_way = w_install ? victim_q : w_hit_way;
    w_old_age   = age_q[w_touch_idx][w_touch_way];
    for (int v = 0; v < WAYS; v++) begin
      w_new_age[v] = age_q[w_touch_idx][v];
      if (v == int'(w_touch_way)) begin
        w_new_age[v] = '0;
      end else if (age_q[w_touch_idx][v] < w_old_age) begin
        w_new_age[v] = age_q[w_touch_idx][v] + AGE_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: flush aborts a fill, last accepted word ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_miss) state_d = S_FILL;
      S_FILL:  if (bus_io.flush || (w_accept && w_last)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the missing block and victim, count accepted words
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mtag_q   <= '0;
      midx_q   <= '0;
      victim_q <= '0;
      cnt_q    <= '0;
    end else if (bus_io.flush) begin
      cnt_q    <= '0;
    end else if (w_miss) begin
      mtag_q   <= w_tag;
      midx_q   <= w_idx;
      victim_q <= w_victim;
      cnt_q    <= '0;
    end else if (w_accept) begin
      cnt_q    <= cnt_q + OFF_W'(1);
    end
  end

  // Valid bits and ages; flush wins over an install in the same cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST || bus_io.flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (w_install) valid_q[midx_q][victim_q] <= 1'b1;
      if (w_touch_en) begin
        for (int v = 0; v < WAYS; v++) age_q[w_touch_idx][v] <= w_new_age[v];
      end
    end
  end

  // Staging buffer and line data/tag write (last word bypasses the buffer)
  always_ff @(posedge CLK) begin
    if (w_accept) buf_q[cnt_q] <= bus_io.iload;
    if (w_install) begin
      ltag_q[midx_q][victim_q] <= mtag_q;
      for (int k = 0; k < WORDS; k++) begin
        data_q[midx_q][victim_q][k] <= (k == int'(cnt_q)) ? bus_io.iload : buf_q[k];
      end
    end
  end

  assign bus_io.iREN     = (state_q == S_FILL);
  assign bus_io.iaddr    = (state_q == S_FILL)
                         ? ((32'({mtag_q, midx_q}) << (2 + OFF_BITS)) | (32'(cnt_q) << 2))
                         : 32'd0;
  assign bus_io.ihit     = w_hit;
  assign bus_io.imemload = w_hit ? data_q[w_idx][w_hit_way][w_off] : 32'd0;

endmodule
`default_nettype wire

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with multi-word blocks. It sits between the pipeline fetch stage and the memory controller, one instance per core, selected by CPUID. Hits return an instruction word combinationally. Misses run a block-fill state machine that fetches every word of the block from memory, then installs the line into a victim way chosen by invalid-first, then true-LRU replacement.

## Interface
Parameters:
- CPUID, 0, core index; carried for controller arbitration and debug only.
- SETS, 8, number of sets; power of 2, from 2 to 64.
- WAYS, 2, associativity; one of 1, 2, 4.
- WORDS, 2, 32-bit words per block; one of 1, 2, 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines (self-modifying code, halt).
- ihit  out  1  imemload is valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word-aligned memory read address.
- iwait  in  1  controller not ready; a word is accepted when iREN && !iwait.
- iload  in  32  memory read data, valid when iREN && !iwait.

## Operation
- Address split, LSB first: 2 byte bits, then log2(WORDS) word offset, then log2(SETS) index, then tag (all remaining bits).
- Storage per set and way: valid bit, tag, WORDS data words, LRU age (log2(WAYS) bits).
- State IDLE:
  - Lookup is combinational. hit = imemREN && a way in the indexed set is valid with a matching tag.
  - On hit: ihit=1, imemload = that way's word at the word offset. Update LRU for the set.
  - On miss (imemREN=1, no match): latch the tag and index, reset word counter cnt=0, pick the victim, go to FILL.
  - When imemREN=0: ihit=0, imemload=0, no state change.
- Victim selection: the lowest-index invalid way if any exists. Otherwise the way with the maximum age.
- LRU update on hit or install of way w:
  - age[w] ← 0.
  - Every way whose age was less than the old age[w] increments by 1.
  - Ages stay a permutation of 0..WAYS-1.
- State FILL:
  - iREN=1, iaddr = {latched tag, latched index, cnt, 2'b00}.
  - Each accepted word is stored into a staging buffer[cnt], then cnt increments.
  - When the word with cnt=WORDS-1 is accepted, the line is written at that edge: data from the staging buffer, tag, valid=1, LRU update. Then the state returns to IDLE.
  - ihit=0 and imemload=0 throughout FILL.
  - Changes to imemaddr or imemREN during FILL are ignored. The fill always completes for the latched block.
- flush:
  - In any state, clears all valid bits and sets every set's ages to 0..WAYS-1 by way index.
  - If the cache is in FILL, the fill is aborted: no line is written and the state returns to IDLE.
  - flush has priority over a line write in the same cycle.
  - ihit=0 in a cycle where flush=1.
- Reset values: state IDLE, all valid=0, ages = way index, cnt=0. Outputs: iREN=0, iaddr=0, ihit=0, imemload=0.

## Timing
- Hit latency is 0 cycles (combinational from imemaddr).
- Miss penalty with iwait=0:
  - Miss seen in cycle 0.
  - FILL runs cycles 1..WORDS, one word accepted per cycle.
  - IDLE in cycle WORDS+1, with ihit=1 in that cycle if the address is unchanged.
- Each cycle with iwait=1 during FILL adds one cycle. iaddr is held stable while iwait=1.
- iREN and iaddr are decoded from registered state only, with no combinational path from imemaddr.
- An asynchronous nRST assertion mid-FILL discards the partial fill. iREN drops immediately.

## Test plan
Defaults: SETS=8, WAYS=2, WORDS=2. 0x00, 0x40 and 0x80 all map to index 0, with tags 0, 1 and 2.
- Cold miss: REN with addr 0x40, iwait=0, iload = 0xAAAA0000 then 0xAAAA0001 → iaddr = 0x40 then 0x44 in cycles 1–2; ihit=1 with imemload=0xAAAA0000 in cycle 3; addr 0x44 then hits with 0xAAAA0001.
- Wait states: same as cold miss with iwait=1 for 3 cycles on the first word → iaddr holds 0x40; ihit arrives in cycle 6.
- LRU eviction: fill 0x00, fill 0x40, hit 0x00, miss 0x80 → 0x80 replaces the 0x40 way; then 0x00 hits and 0x40 misses.
- Flush mid-fill: assert flush in cycle 1 of a fill of 0x40 → iREN=0 in the next cycle; a later access to 0x40 misses; previously valid 0x00 also misses.
- Address change mid-fill: miss on 0x40, then switch imemaddr to 0x80 in cycle 1 → the fill of 0x40/0x44 completes; in IDLE, 0x80 misses and starts a new fill.
- Reset mid-fill: drop nRST in cycle 1 → iREN, ihit and imemload are 0 immediately; after release, all accesses miss.
